// File: rtl/regfile_2w2r_if.sv
// ============================================================================
// Module   : regfile_2w2r_if
// Brief    : Write, read and scoreboard bundle for the dual-write register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_2w2r_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              RegWriteA;
  logic [ADDR_W-1:0] WriteRegA;
  logic [DATA_W-1:0] WriteDataA;
  logic              RegWriteB;
  logic [ADDR_W-1:0] WriteRegB;
  logic [DATA_W-1:0] WriteDataB;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              Reserve;
  logic [ADDR_W-1:0] ReserveReg;
  logic              Busy1;
  logic              Busy2;
  logic              WriteConflict;

  modport master (
    output RegWriteA, WriteRegA, WriteDataA,
    output RegWriteB, WriteRegB, WriteDataB,
    output ReadReg1, ReadReg2, Reserve, ReserveReg,
    input  ReadData1, ReadData2, Busy1, Busy2, WriteConflict
  );

  modport slave (
    input  RegWriteA, WriteRegA, WriteDataA,
    input  RegWriteB, WriteRegB, WriteDataB,
    input  ReadReg1, ReadReg2, Reserve, ReserveReg,
    output ReadData1, ReadData2, Busy1, Busy2, WriteConflict
  );
endinterface

`default_nettype wire

// File: rtl/regfile_2w2r.sv
// ============================================================================
// Module   : regfile_2w2r
// Brief    : Two-write/two-read register file, reg 0 hardwired to zero, with a
//            per-register busy scoreboard and a registered write-collision flag.
//            Optional same-cycle write forwarding: define REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_2w2r #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2**ADDR_W
) (
  input  logic            clk,
  input  logic            rst_n,
  regfile_2w2r_if.slave   bus
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] we_a;
  logic [NUM_REGS-1:0] we_b;
  logic [NUM_REGS-1:0] res_hit;
  logic                conflict;
  logic                collide;
  logic                in_range1;
  logic                in_range2;
  logic [DATA_W-1:0]   rd1;
  logic [DATA_W-1:0]   rd2;
  logic                busy1;
  logic                busy2;

  // Entry 0 never decodes, so reg 0 and busy[0] keep their reset value of zero.
  always_comb begin
    we_a    = '0;
    we_b    = '0;
    res_hit = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      we_a[r]    = bus.RegWriteA && (bus.WriteRegA  == ADDR_W'(r));
      we_b[r]    = bus.RegWriteB && (bus.WriteRegB  == ADDR_W'(r));
      res_hit[r] = bus.Reserve   && (bus.ReserveReg == ADDR_W'(r));
    end
  end

  assign collide = bus.RegWriteA && bus.RegWriteB &&
                   (bus.WriteRegA == bus.WriteRegB) && (bus.WriteRegA != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
      busy     <= '0;
      conflict <= 1'b0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (we_b[r]) begin
          regs[r] <= bus.WriteDataB;
        end else if (we_a[r]) begin
          regs[r] <= bus.WriteDataA;
        end
        // A new reservation outranks the retiring write of the old producer.
        if (res_hit[r]) begin
          busy[r] <= 1'b1;
        end else if (we_a[r] || we_b[r]) begin
          busy[r] <= 1'b0;
        end
      end
      conflict <= collide;
    end
  end

  assign in_range1 = (int'(bus.ReadReg1) < NUM_REGS) && (bus.ReadReg1 != '0);
  assign in_range2 = (int'(bus.ReadReg2) < NUM_REGS) && (bus.ReadReg2 != '0);

`ifdef REGFILE_BYPASS_EN
  logic hit_a1;
  logic hit_b1;
  logic hit_a2;
  logic hit_b2;
  logic res1;
  logic res2;

  assign hit_a1 = in_range1 && bus.RegWriteA && (bus.WriteRegA == bus.ReadReg1);
  assign hit_b1 = in_range1 && bus.RegWriteB && (bus.WriteRegB == bus.ReadReg1);
  assign hit_a2 = in_range2 && bus.RegWriteA && (bus.WriteRegA == bus.ReadReg2);
  assign hit_b2 = in_range2 && bus.RegWriteB && (bus.WriteRegB == bus.ReadReg2);
  assign res1   = bus.Reserve && (bus.ReserveReg == bus.ReadReg1);
  assign res2   = bus.Reserve && (bus.ReserveReg == bus.ReadReg2);

  always_comb begin
    rd1   = '0;
    rd2   = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (rst_n && in_range1) begin
      busy1 = busy[bus.ReadReg1];
      if (hit_b1) begin
        rd1 = bus.WriteDataB;
      end else if (hit_a1) begin
        rd1 = bus.WriteDataA;
      end else begin
        rd1 = regs[bus.ReadReg1];
      end
      if ((hit_a1 || hit_b1) && !res1) begin
        busy1 = 1'b0;
      end
    end
    if (rst_n && in_range2) begin
      busy2 = busy[bus.ReadReg2];
      if (hit_b2) begin
        rd2 = bus.WriteDataB;
      end else if (hit_a2) begin
        rd2 = bus.WriteDataA;
      end else begin
        rd2 = regs[bus.ReadReg2];
      end
      if ((hit_a2 || hit_b2) && !res2) begin
        busy2 = 1'b0;
      end
    end
  end
`else
  always_comb begin
    rd1   = '0;
    rd2   = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (rst_n && in_range1) begin
      rd1   = regs[bus.ReadReg1];
      busy1 = busy[bus.ReadReg1];
    end
    if (rst_n && in_range2) begin
      rd2   = regs[bus.ReadReg2];
      busy2 = busy[bus.ReadReg2];
    end
  end
`endif

  assign bus.ReadData1     = rd1;
  assign bus.ReadData2     = rd2;
  assign bus.Busy1         = busy1;
  assign bus.Busy2         = busy2;
  assign bus.WriteConflict = conflict;

endmodule

`default_nettype wire

// File: tb/tb_regfile_2w2r.sv
// ============================================================================
// Module   : tb_regfile_2w2r
// Brief    : Directed self-checking bench for regfile_2w2r (NUM_REGS = 24).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_2w2r;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic [31:0] exp_regs [24];

  always #5 clk = ~clk;

  regfile_2w2r_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic idle();
    bus.RegWriteA  = 1'b0;
    bus.WriteRegA  = '0;
    bus.WriteDataA = '0;
    bus.RegWriteB  = 1'b0;
    bus.WriteRegB  = '0;
    bus.WriteDataB = '0;
    bus.Reserve    = 1'b0;
    bus.ReserveReg = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.ReadReg1   = 5'd3;
    bus.ReadReg2   = 5'd4;
    bus.RegWriteA  = 1'b1;
    bus.WriteRegA  = 5'd4;
    bus.WriteDataA = 32'h4444_4444;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.ReadData1 !== 32'h0) $display("FAIL reset_rd1 got %h want %h", bus.ReadData1, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (bus.Busy1 !== 1'b0) $display("FAIL reset_busy1 got %b want 0", bus.Busy1);
    else pass_cnt++;
    total_cnt++;
    if (bus.WriteConflict !== 1'b0) $display("FAIL reset_conflict got %b want 0", bus.WriteConflict);
    else pass_cnt++;

    @(negedge clk);
    rst_n = 1'b1;
    idle();
    bus.RegWriteA  = 1'b1;
    bus.WriteRegA  = 5'd3;
    bus.WriteDataA = 32'h1111_2222;
    @(posedge clk);
    #1;
    idle();
    #1;
    total_cnt++;
    if (bus.ReadData1 !== 32'h1111_2222) $display("FAIL write_r3 got %h want %h", bus.ReadData1, 32'h1111_2222);
    else pass_cnt++;
    total_cnt++;
    if (bus.ReadData2 !== 32'h0) $display("FAIL write_in_reset_r4 got %h want %h", bus.ReadData2, 32'h0);
    else pass_cnt++;

    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.ReadData1 !== 32'h0) $display("FAIL mid_reset_rd1 got %h want %h", bus.ReadData1, 32'h0);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.ReadData1 !== 32'h0) $display("FAIL after_reset_r3 got %h want %h", bus.ReadData1, 32'h0);
    else pass_cnt++;

    @(negedge clk);
    bus.RegWriteA  = 1'b1;
    bus.WriteRegA  = 5'd0;
    bus.WriteDataA = 32'hFFFF_FFFF;
    bus.ReadReg1   = 5'd0;
    @(posedge clk);
    #1;
    idle();
    #1;
    total_cnt++;
    if (bus.ReadData1 !== 32'h0) $display("FAIL reg0_zero got %h want %h", bus.ReadData1, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    bus.RegWriteA  = 1'b1;
    bus.WriteRegA  = 5'd5;
    bus.WriteDataA = 32'hABCD_1234;
    bus.RegWriteB  = 1'b1;
    bus.WriteRegB  = 5'd10;
    bus.WriteDataB = 32'h1234_5678;
    @(posedge clk);
    #1;
    idle();
    bus.ReadReg1 = 5'd5;
    bus.ReadReg2 = 5'd10;
    #1;
    total_cnt++;
    if (bus.ReadData1 !== 32'hABCD_1234) $display("FAIL dual_r5 got %h want %h", bus.ReadData1, 32'hABCD_1234);
    else pass_cnt++;
    total_cnt++;
    if (bus.ReadData2 !== 32'h1234_5678) $display("FAIL dual_r10 got %h want %h", bus.ReadData2, 32'h1234_5678);
    else pass_cnt++;
    total_cnt++;
    if (bus.WriteConflict !== 1'b0) $display("FAIL dual_no_conflict got %b want 0", bus.WriteConflict);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    @(negedge clk);
    bus.RegWriteA  = 1'b1;
    bus.WriteRegA  = 5'd7;
    bus.WriteDataA = 32'h0000_00AA;
    bus.RegWriteB  = 1'b1;
    bus.WriteRegB  = 5'd7;
    bus.WriteDataB = 32'h0000_00BB;
    bus.ReadReg1   = 5'd7;
    #1;
    total_cnt++;
    if (bus.WriteConflict !== 1'b0) $display("FAIL coll_pre_edge got %b want 0", bus.WriteConflict);
    else pass_cnt++;
    @(posedge clk);
    #1;
    idle();
    #1;
    total_cnt++;
    if (bus.WriteConflict !== 1'b1) $display("FAIL coll_flag got %b want 1", bus.WriteConflict);
    else pass_cnt++;
    total_cnt++;
    if (bus.ReadData1 !== 32'h0000_00BB) $display("FAIL coll_b_wins got %h want %h", bus.ReadData1, 32'h0000_00BB);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.WriteConflict !== 1'b0) $display("FAIL coll_one_cycle got %b want 0", bus.WriteConflict);
    else pass_cnt++;

    @(negedge clk);
    bus.RegWriteA  = 1'b1;
    bus.WriteRegA  = 5'd0;
    bus.WriteDataA = 32'h11;
    bus.RegWriteB  = 1'b1;
    bus.WriteRegB  = 5'd0;
    bus.WriteDataB = 32'h22;
    bus.ReadReg1   = 5'd0;
    @(posedge clk);
    #1;
    idle();
    #1;
    total_cnt++;
    if (bus.WriteConflict !== 1'b0) $display("FAIL coll_reg0_flag got %b want 0", bus.WriteConflict);
    else pass_cnt++;
    total_cnt++;
    if (bus.ReadData1 !== 32'h0) $display("FAIL coll_reg0_data got %h want %h", bus.ReadData1, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    bus.ReadReg1   = 5'd9;
    bus.ReadReg2   = 5'd10;
    bus.Reserve    = 1'b1;
    bus.ReserveReg = 5'd9;
    #1;
    total_cnt++;
    if (bus.Busy1 !== 1'b0) $display("FAIL sb_pre_reserve got %b want 0", bus.Busy1);
    else pass_cnt++;
    @(posedge clk);
    #1;
    idle();
    #1;
    total_cnt++;
    if (bus.Busy1 !== 1'b1) $display("FAIL sb_reserved got %b want 1", bus.Busy1);
    else pass_cnt++;
    total_cnt++;
    if (bus.Busy2 !== 1'b0) $display("FAIL sb_other_idle got %b want 0", bus.Busy2);
    else pass_cnt++;

    @(negedge clk);
    bus.RegWriteB  = 1'b1;
    bus.WriteRegB  = 5'd9;
    bus.WriteDataB = 32'h0000_0099;
    #1;
    total_cnt++;
    if (bus.Busy1 !== !BYPASS) $display("FAIL sb_write_pre_edge got %b want %b", bus.Busy1, !BYPASS);
    else pass_cnt++;
    @(posedge clk);
    #1;
    idle();
    #1;
    total_cnt++;
    if (bus.Busy1 !== 1'b0) $display("FAIL sb_cleared got %b want 0", bus.Busy1);
    else pass_cnt++;
    total_cnt++;
    if (bus.ReadData1 !== 32'h0000_0099) $display("FAIL sb_write_data got %h want %h", bus.ReadData1, 32'h0000_0099);
    else pass_cnt++;

    @(negedge clk);
    bus.Reserve    = 1'b1;
    bus.ReserveReg = 5'd9;
    bus.RegWriteA  = 1'b1;
    bus.WriteRegA  = 5'd9;
    bus.WriteDataA = 32'h0000_0909;
    @(posedge clk);
    #1;
    idle();
    #1;
    total_cnt++;
    if (bus.Busy1 !== 1'b1) $display("FAIL sb_reserve_wins got %b want 1", bus.Busy1);
    else pass_cnt++;
    total_cnt++;
    if (bus.ReadData1 !== 32'h0000_0909) $display("FAIL sb_reserve_data got %h want %h", bus.ReadData1, 32'h0000_0909);
    else pass_cnt++;

    @(negedge clk);
    bus.Reserve    = 1'b1;
    bus.ReserveReg = 5'd9;
    bus.RegWriteA  = 1'b1;
    bus.WriteRegA  = 5'd10;
    bus.WriteDataA = 32'h1234_5678;
    @(posedge clk);
    #1;
    idle();
    #1;
    total_cnt++;
    if (bus.Busy1 !== 1'b1) $display("FAIL sb_rereserve got %b want 1", bus.Busy1);
    else pass_cnt++;
    total_cnt++;
    if (bus.Busy2 !== 1'b0) $display("FAIL sb_nonbusy_write got %b want 0", bus.Busy2);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    bus.ReadReg1   = 5'd5;
    bus.RegWriteA  = 1'b1;
    bus.WriteRegA  = 5'd5;
    bus.WriteDataA = 32'h8765_4321;
    #1;
    total_cnt++;
    if (bus.ReadData1 !== (BYPASS ? 32'h8765_4321 : 32'hABCD_1234))
      $display("FAIL byp_pre_edge got %h want %h", bus.ReadData1, (BYPASS ? 32'h8765_4321 : 32'hABCD_1234));
    else pass_cnt++;
    @(posedge clk);
    #1;
    idle();
    #1;
    total_cnt++;
    if (bus.ReadData1 !== 32'h8765_4321) $display("FAIL byp_post_edge got %h want %h", bus.ReadData1, 32'h8765_4321);
    else pass_cnt++;

    @(negedge clk);
    bus.ReadReg2   = 5'd10;
    bus.RegWriteA  = 1'b1;
    bus.WriteRegA  = 5'd10;
    bus.WriteDataA = 32'h0A0A_0A0A;
    bus.RegWriteB  = 1'b1;
    bus.WriteRegB  = 5'd10;
    bus.WriteDataB = 32'h0B0B_0B0B;
    #1;
    total_cnt++;
    if (bus.ReadData2 !== (BYPASS ? 32'h0B0B_0B0B : 32'h1234_5678))
      $display("FAIL byp_both_pre got %h want %h", bus.ReadData2, (BYPASS ? 32'h0B0B_0B0B : 32'h1234_5678));
    else pass_cnt++;
    @(posedge clk);
    #1;
    idle();
    #1;
    total_cnt++;
    if (bus.ReadData2 !== 32'h0B0B_0B0B) $display("FAIL byp_both_post got %h want %h", bus.ReadData2, 32'h0B0B_0B0B);
    else pass_cnt++;
    total_cnt++;
    if (bus.WriteConflict !== 1'b1) $display("FAIL byp_both_conflict got %b want 1", bus.WriteConflict);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    bus.RegWriteA  = 1'b1;
    bus.WriteRegA  = 5'd30;
    bus.WriteDataA = 32'hDEAD_BEEF;
    bus.Reserve    = 1'b1;
    bus.ReserveReg = 5'd30;
    bus.ReadReg1   = 5'd30;
    #1;
    total_cnt++;
    if (bus.ReadData1 !== 32'h0) $display("FAIL oor_pre_data got %h want %h", bus.ReadData1, 32'h0);
    else pass_cnt++;
    @(posedge clk);
    #1;
    idle();
    #1;
    total_cnt++;
    if (bus.ReadData1 !== 32'h0) $display("FAIL oor_data got %h want %h", bus.ReadData1, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (bus.Busy1 !== 1'b0) $display("FAIL oor_busy got %b want 0", bus.Busy1);
    else pass_cnt++;

    for (int r = 0; r < 24; r++) exp_regs[r] = 32'h0;
    exp_regs[5]  = 32'h8765_4321;
    exp_regs[7]  = 32'h0000_00BB;
    exp_regs[9]  = 32'h0000_0909;
    exp_regs[10] = 32'h0B0B_0B0B;
    for (int r = 0; r < 24; r++) begin
      bus.ReadReg1 = 5'(r);
      bus.ReadReg2 = 5'(r);
      #1;
      total_cnt++;
      if (bus.ReadData1 !== exp_regs[r]) $display("FAIL oor_sweep_r%0d got %h want %h", r, bus.ReadData1, exp_regs[r]);
      else pass_cnt++;
      total_cnt++;
      if (bus.Busy2 !== (r == 9)) $display("FAIL oor_busy_r%0d got %b want %b", r, bus.Busy2, (r == 9));
      else pass_cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    bus.ReadReg1 = '0;
    bus.ReadReg2 = '0;
    test_reset();
    test_dual_write();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_out_of_range();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
